serial_adder_logic_ops: RTL and testbench

Bit-serial adder that adds two operands presented one bit per clock, least-significant bit first. It produces the matching sum bit in the same cycle. The carry between bit positions lives in a single flip-flop. The sum and carry logic use only bitwise logic operators (AND, OR, XOR); no arithmetic operator is allowed. It sits in the sequential-basics datapath as a drop-in equivalent of the behavioural `serial_adder`.

---
 rtl/serial_adder_pkg.sv | 7 +
 rtl/full_adder_bit.sv | 17 +
 rtl/serial_adder_logic_ops.sv | 41 ++++
 tb/tb_serial_adder_logic_ops.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// Optional carry_out port is enabled with SERIAL_ADDER_CARRY_OUT_EN.
package serial_adder_pkg;

    localparam logic CARRY_RESET_VAL = 1'b0;

endpackage : serial_adder_pkg

// File: rtl/full_adder_bit.sv
// Single-bit full adder built purely from XOR/AND/OR gates.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x;

    assign ab_x = a ^ b;
    assign s    = ab_x ^ cin;
    // Majority function: carry whenever at least two inputs are set.
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/serial_adder_logic_ops.sv
// Bit-serial adder, LSB first, carry held in one flop between bit positions.
// Define SERIAL_ADDER_CARRY_OUT_EN to expose the carry register on carry_out.
module serial_adder_logic_ops
    import serial_adder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic sum
`ifdef SERIAL_ADDER_CARRY_OUT_EN
    ,
    output logic carry_out
`endif
);

    logic c;
    logic c_next;

    full_adder_bit u_fa (
        .a    (a),
        .b    (b),
        .cin  (c),
        .s    (sum),
        .cout (c_next)
    );

    // Asynchronous clear discards any partial word; the next cycle is bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c <= CARRY_RESET_VAL;
        end else begin
            c <= c_next;
        end
    end

`ifdef SERIAL_ADDER_CARRY_OUT_EN
    assign carry_out = c;
`endif

endmodule : serial_adder_logic_ops

// File: tb/tb_serial_adder_logic_ops.sv
// Self-checking bench for serial_adder_logic_ops against an arithmetic reference model.
module tb_serial_adder_logic_ops;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic sum;
    logic carry_out;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    serial_adder_logic_ops dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sum       (sum)
`ifdef SERIAL_ADDER_CARRY_OUT_EN
        ,
        .carry_out (carry_out)
`endif
    );

`ifndef SERIAL_ADDER_CARRY_OUT_EN
    assign carry_out = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit pair mid-cycle, sample sum before the next rising edge.
    task automatic apply_bit(input logic ai, input logic bi, output logic s);
        @(negedge clk);
        a = ai;
        b = bi;
        #1;
        s = sum;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        a = 1'b0;
        b = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic stream_word(input logic [15:0] wa, input logic [15:0] wb, output logic [15:0] got);
        logic s;
        for (int i = 0; i < 16; i++) begin
            apply_bit(wa[i], wb[i], s);
            got[i] = s;
        end
    endtask

    initial begin
        logic s;
        logic [15:0] got;
        logic [16:0] ref_sum;
        logic [15:0] ra, rb;
        logic [1:0] row;

        rst = 1'b0;
        a = 1'b1;
        b = 1'b0;
        #1;
        check("reset_sum_10", sum, 1);
        check("reset_carry_out", carry_out, 0);
        a = 1'b1;
        b = 1'b1;
        #1;
        check("reset_sum_11", sum, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed word 0x4DB4 + 0x1D62.
        do_reset();
        stream_word(16'h4DB4, 16'h1D62, got);
        check("word_4db4_1d62", got, 32'h6B16);

        // All-ones plus one: carry must survive past the last bit.
        do_reset();
        stream_word(16'hFFFF, 16'h0001, got);
        check("word_ffff_0001", got, 0);
`ifdef SERIAL_ADDER_CARRY_OUT_EN
        #1;
        check("ffff_carry_out", carry_out, 1);
`endif
        apply_bit(1'b0, 1'b0, s);
        check("ffff_carry_flush", s, 1);

        // Two-bit carry propagation.
        do_reset();
        apply_bit(1'b1, 1'b1, s);
        check("two_bit_c0", s, 0);
        apply_bit(1'b0, 1'b0, s);
        check("two_bit_c1", s, 1);
        apply_bit(1'b0, 1'b0, s);
        check("two_bit_c2", s, 0);

        // Reset pulse between edges discards a pending carry.
        do_reset();
        apply_bit(1'b1, 1'b1, s);
        check("mid_load", s, 0);
        @(negedge clk);
        a = 1'b0;
        b = 1'b0;
        #1;
        check("mid_pre_pulse", sum, 1);
        rst = 1'b0;
        #1;
        check("mid_in_pulse_sum", sum, 0);
        check("mid_in_pulse_carry", carry_out, 0);
        rst = 1'b1;
        #1;
        check("mid_post_pulse", sum, 0);
        @(posedge clk);
        apply_bit(1'b0, 1'b0, s);
        check("mid_next_bit", s, 0);

        // Full-adder truth table, carry held at 0 then 1.
        for (int cin = 0; cin < 2; cin++) begin
            for (int r = 0; r < 4; r++) begin
                row = r[1:0];
                do_reset();
                if (cin == 1) begin
                    apply_bit(1'b1, 1'b1, s);
                    check("tt_preload", s, 0);
                end
                ref_sum = 17'(row[1]) + 17'(row[0]) + 17'(cin);
                apply_bit(row[1], row[0], s);
                check($sformatf("tt_sum_c%0d_ab%0d", cin, r), s, ref_sum[0]);
                apply_bit(1'b0, 1'b0, s);
                check($sformatf("tt_cnext_c%0d_ab%0d", cin, r), s, ref_sum[1]);
            end
        end

        // Random words, every bit compared against an arithmetic model.
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            rb = 16'($urandom_range(0, 16'hFFFF));
            ref_sum = 17'(ra) + 17'(rb);
            for (int i = 0; i < 17; i++) exp_q.push_back(ref_sum[i]);
            do_reset();
            for (int i = 0; i < 17; i++) begin
                if (i < 16) apply_bit(ra[i], rb[i], s);
                else        apply_bit(1'b0, 1'b0, s);
                check($sformatf("rand%0d_bit%0d", n, i), s, exp_q.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder_logic_ops
